reg_file_sb: RTL and testbench

Parametrised register file with a per-register busy scoreboard, built on the same decode/select structure as the datapath's channel mux/demux/encode/decode primitives. It has one write port and two synchronous read ports (A and B) with write-to-read bypass. It also keeps a busy bit per register: the bit is set when an instruction that will produce that register issues, and cleared when the register is written back. The block sits between decode/issue and the execute stage and replaces the fixed 32×20-bit channel select.

---
 rtl/reg_file_sb.sv | 96 +++++++++
 tb/tb_reg_file_sb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file_sb : register file with a per-register busy scoreboard, one write
//               port and two registered, write-bypassed read ports.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module reg_file_sb #(
  parameter int WIDTH    = 20,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [WIDTH-1:0]  ra_data,
  output logic [WIDTH-1:0]  rb_data,
  output logic              ra_busy,
  output logic              rb_busy,
  output logic [ADDR_W:0]   busy_count
);

  localparam logic ZR = (ZERO_REG != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] ra_data_q, ra_data_d, rb_data_q, rb_data_d;
  logic             ra_busy_q, ra_busy_d, rb_busy_q, rb_busy_d;
  logic [ADDR_W:0]  busy_count_q, busy_count_d;

  logic we_eff, mark_eff, set_new, clr_new;

  always_comb begin
    we_eff   = we && !(ZR && waddr == '0);
    mark_eff = mark_en && !(ZR && mark_addr == '0);
    // A clear that collides with a mark on the same index is overridden.
    set_new  = mark_eff && !busy_q[mark_addr];
    clr_new  = we_eff && busy_q[waddr] && !(mark_eff && mark_addr == waddr);

    mem_d  = mem_q;
    busy_d = busy_q;
    if (we_eff) begin
      mem_d[waddr]  = wdata;
      busy_d[waddr] = 1'b0;
    end
    if (mark_eff) begin
      busy_d[mark_addr] = 1'b1;
    end

    busy_count_d = busy_count_q + {{ADDR_W{1'b0}}, set_new}
                                - {{ADDR_W{1'b0}}, clr_new};

    // Reading the post-update state gives both data and busy bypass.
    ra_data_d = mem_d[ra_addr];
    rb_data_d = mem_d[rb_addr];
    ra_busy_d = busy_d[ra_addr];
    rb_busy_d = busy_d[rb_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
      ra_data_q    <= '0;
      rb_data_q    <= '0;
      ra_busy_q    <= 1'b0;
      rb_busy_q    <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      ra_data_q    <= ra_data_d;
      rb_data_q    <= rb_data_d;
      ra_busy_q    <= ra_busy_d;
      rb_busy_q    <= rb_busy_d;
    end
  end

  assign ra_data    = ra_data_q;
  assign rb_data    = rb_data_q;
  assign ra_busy    = ra_busy_q;
  assign rb_busy    = rb_busy_q;
  assign busy_count = busy_count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// tb_reg_file_sb : vector table, corner sequences and random traffic for
// reg_file_sb at default parameters and at WIDTH=8, DEPTH=4, ZERO_REG=0.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        we0, mk0;
  logic [4:0]  wa0, ma0, ra0, rb0;
  logic [19:0] wd0, rad0, rbd0;
  logic        rab0, rbb0;
  logic [5:0]  cnt0;

  logic        we1, mk1;
  logic [1:0]  wa1, ma1, ra1, rb1;
  logic [7:0]  wd1, rad1, rbd1;
  logic        rab1, rbb1;
  logic [2:0]  cnt1;

  reg_file_sb u_dut0 (
    .clk(clk), .rst(rst), .we(we0), .waddr(wa0), .wdata(wd0),
    .mark_en(mk0), .mark_addr(ma0), .ra_addr(ra0), .rb_addr(rb0),
    .ra_data(rad0), .rb_data(rbd0), .ra_busy(rab0), .rb_busy(rbb0),
    .busy_count(cnt0)
  );

  reg_file_sb #(.WIDTH(8), .DEPTH(4), .ZERO_REG(0)) u_dut1 (
    .clk(clk), .rst(rst), .we(we1), .waddr(wa1), .wdata(wd1),
    .mark_en(mk1), .mark_addr(ma1), .ra_addr(ra1), .rb_addr(rb1),
    .ra_data(rad1), .rb_data(rbd1), .ra_busy(rab1), .rb_busy(rbb1),
    .busy_count(cnt1)
  );

  int checks = 0;
  int errors = 0;

  // Architectural state of each instance as it stands after each edge.
  int unsigned m_mem  [2][32];
  bit          m_busy [2][32];
  int          m_depth [2] = '{32, 4};
  int unsigned m_mask  [2] = '{32'h000FFFFF, 32'h000000FF};
  bit          m_zero  [2] = '{1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int popcount(input int k);
    int n = 0;
    for (int i = 0; i < m_depth[k]; i++) n += int'(m_busy[k][i]);
    return n;
  endfunction

  task automatic model_step(input int k, input bit r, input bit w, input int wa,
                            input int unsigned wd, input bit m, input int ma);
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i]  = 0;
        m_busy[k][i] = 1'b0;
      end
    end else begin
      if (w && !(m_zero[k] && wa == 0)) begin
        m_mem[k][wa]  = wd & m_mask[k];
        m_busy[k][wa] = 1'b0;
      end
      if (m && !(m_zero[k] && ma == 0)) m_busy[k][ma] = 1'b1;
    end
  endtask

  // One clock: drive both instances, advance the model, compare after the edge.
  task automatic cycle(input bit r, input bit w, input int wa, input int unsigned wd,
                       input bit m, input int ma, input int a, input int b);
    rst = r;
    we0 = w; wa0 = 5'(wa); wd0 = 20'(wd); mk0 = m; ma0 = 5'(ma); ra0 = 5'(a); rb0 = 5'(b);
    we1 = w; wa1 = 2'(wa); wd1 = 8'(wd);  mk1 = m; ma1 = 2'(ma); ra1 = 2'(a); rb1 = 2'(b);
    model_step(0, r, w, wa % 32, wd, m, ma % 32);
    model_step(1, r, w, wa % 4,  wd, m, ma % 4);
    @(posedge clk);
    #1;
    check("dut0 ra_data", 32'(rad0), m_mem[0][a % 32]);
    check("dut0 rb_data", 32'(rbd0), m_mem[0][b % 32]);
    check("dut0 ra_busy", 32'(rab0), 32'(m_busy[0][a % 32]));
    check("dut0 rb_busy", 32'(rbb0), 32'(m_busy[0][b % 32]));
    check("dut0 busy_count", 32'(cnt0), 32'(popcount(0)));
    check("dut1 ra_data", 32'(rad1), m_mem[1][a % 4]);
    check("dut1 rb_data", 32'(rbd1), m_mem[1][b % 4]);
    check("dut1 ra_busy", 32'(rab1), 32'(m_busy[1][a % 4]));
    check("dut1 rb_busy", 32'(rbb1), 32'(m_busy[1][b % 4]));
    check("dut1 busy_count", 32'(cnt1), 32'(popcount(1)));
  endtask

  typedef struct packed {
    bit          r;
    bit          w;
    int          wa;
    int unsigned wd;
    bit          m;
    int          ma;
    int          a;
    int          b;
    int unsigned e_ra;
    int unsigned e_rb;
    bit          e_rab;
    bit          e_rbb;
    int          e_cnt;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           r     w     wa  wd        m     ma  a   b   e_ra      e_rb      rab   rbb   cnt
    tbl[0]  = '{1'b1, 1'b1, 5,  'hABCDE, 1'b0, 0,  5,  5,  'h0,     'h0,     1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b1, 5,  'hABCDE, 1'b0, 0,  5,  5,  'h0,     'h0,     1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b0, 0,  'h0,     1'b0, 0,  5,  5,  'h0,     'h0,     1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1, 7,  'h12345, 1'b0, 0,  0,  0,  'h0,     'h0,     1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b0, 0,  'h0,     1'b0, 0,  7,  7,  'h12345, 'h12345, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b1, 7,  'h0F0F0, 1'b0, 0,  7,  0,  'h0F0F0, 'h0,     1'b0, 1'b0, 0};
    tbl[6]  = '{1'b0, 1'b1, 0,  'hFFFFF, 1'b1, 0,  0,  0,  'h0,     'h0,     1'b0, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b0, 0,  'h0,     1'b1, 3,  3,  0,  'h0,     'h0,     1'b1, 1'b0, 1};
    tbl[8]  = '{1'b0, 1'b0, 0,  'h0,     1'b1, 9,  3,  9,  'h0,     'h0,     1'b1, 1'b1, 2};
    tbl[9]  = '{1'b0, 1'b1, 3,  'h00333, 1'b0, 0,  3,  9,  'h00333, 'h0,     1'b0, 1'b1, 1};
    tbl[10] = '{1'b0, 1'b1, 3,  'h00444, 1'b1, 3,  3,  3,  'h00444, 'h00444, 1'b1, 1'b1, 2};
    tbl[11] = '{1'b0, 1'b1, 31, 'hFFFFF, 1'b0, 0,  31, 31, 'hFFFFF, 'hFFFFF, 1'b0, 1'b0, 2};
    tbl[12] = '{1'b0, 1'b0, 0,  'h0,     1'b0, 0,  31, 7,  'hFFFFF, 'h0F0F0, 1'b0, 1'b0, 2};
    tbl[13] = '{1'b0, 1'b1, 9,  'h00009, 1'b1, 9,  9,  3,  'h00009, 'h00444, 1'b1, 1'b1, 2};
    tbl[14] = '{1'b0, 1'b1, 7,  'h77777, 1'b0, 0,  7,  9,  'h77777, 'h00009, 1'b0, 1'b1, 2};

    rst = 1'b1;
    we0 = 1'b0; wa0 = '0; wd0 = '0; mk0 = 1'b0; ma0 = '0; ra0 = '0; rb0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0; mk1 = 1'b0; ma1 = '0; ra1 = '0; rb1 = '0;
    for (int i = 0; i < 2; i++) model_step(i, 1'b1, 1'b0, 0, 0, 1'b0, 0);

    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].r, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].m, tbl[i].ma, tbl[i].a, tbl[i].b);
      check($sformatf("vec%0d ra_data", i), 32'(rad0), tbl[i].e_ra);
      check($sformatf("vec%0d rb_data", i), 32'(rbd0), tbl[i].e_rb);
      check($sformatf("vec%0d ra_busy", i), 32'(rab0), 32'(tbl[i].e_rab));
      check($sformatf("vec%0d rb_busy", i), 32'(rbb0), 32'(tbl[i].e_rbb));
      check($sformatf("vec%0d busy_count", i), 32'(cnt0), 32'(tbl[i].e_cnt));
    end

    // Claim every register: the count saturates at the register population.
    for (int i = 1; i < 32; i++) cycle(1'b0, 1'b0, 0, 0, 1'b1, i, i, 0);
    check("mark all count dut0", 32'(cnt0), 32'd31);
    check("mark all count dut1", 32'(cnt1), 32'd4);

    // Write and mark on different indices in one cycle.
    cycle(1'b0, 1'b1, 5, 'h55555, 1'b1, 6, 5, 6);
    check("split write/mark count", 32'(cnt0), 32'd30);
    check("split write/mark rb_busy", 32'(rbb0), 32'd1);

    // Reset in the middle of traffic, with write and mark asserted.
    cycle(1'b1, 1'b1, 12, 'h12, 1'b1, 12, 31, 12);
    check("mid reset count", 32'(cnt0), 32'd0);
    check("mid reset ra_data", 32'(rad0), 32'd0);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 0, 31, 6);
    check("after reset r31", 32'(rad0), 32'd0);
    check("after reset r6 busy", 32'(rbb0), 32'd0);

    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
